// File: rtl/tick_period_meter.sv
// tick_period_meter: measures cin-cycle spacing between rising edges of pin.
// Ports:
//   cin, reset (sync, active-high), pin (async pulse input)
//   period/period_valid (last spacing + 1-cycle strobe)
//   timeout (no edge seen for TIMEOUT cycles)
//   meas_count (completed measurements, wraps)
// Optional: define TICK_PERIOD_MINMAX_EN to add period_min/period_max.
module tick_period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [31:0] TIMEOUT = 32'd100000000
) (
  input  logic             cin,
  input  logic             reset,
  input  logic             pin,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic [7:0]       meas_count
`ifdef TICK_PERIOD_MINMAX_EN
  ,
  output logic [WIDTH-1:0] period_min,
  output logic [WIDTH-1:0] period_max
`endif
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_LAST =
    WIDTH'(TIMEOUT - 32'd1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic [7:0]       meas_q, meas_d;

  logic             rise;
  logic             meas_done;
  logic [WIDTH-1:0] new_period;

  assign rise       = s2_q & ~s3_q;
  assign meas_done  = (state_q == MEASURE) & rise;
  // cnt counts cycles after the previous edge, so spacing is cnt+1
  assign new_period = cnt_q + ONE;

  always_ff @(posedge cin) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pin;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;
    meas_d   = meas_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // an edge on the last count cycle still counts
        if (rise) begin
          period_d = new_period;
          valid_d  = 1'b1;
          meas_d   = meas_q + 8'd1;
          tmo_d    = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge cin) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      meas_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      meas_q   <= meas_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = tmo_q;
  assign meas_count   = meas_q;

`ifdef TICK_PERIOD_MINMAX_EN
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (meas_done) begin
      if (new_period < min_q) min_d = new_period;
      if (new_period > max_q) max_d = new_period;
    end
  end

  always_ff @(posedge cin) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign period_min = min_q;
  assign period_max = max_q;
`endif

endmodule
